// File: rtl/mux_scan_if.sv
// mux_scan_if: data, select and status bundle of the scanning channel mux.
// master drives channels and controls, slave returns the registered selection.
interface mux_scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS-1:0]       chan_en;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          sel_out;
  logic [CHANNELS-1:0]       onehot_out;
  logic                      chg_out;

  modport master (
    output din,
    output mode,
    output sel_in,
    output chan_en,
    input  dout,
    input  sel_out,
    input  onehot_out,
    input  chg_out
  );

  modport slave (
    input  din,
    input  mode,
    input  sel_in,
    input  chan_en,
    output dout,
    output sel_out,
    output onehot_out,
    output chg_out
  );
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N:1 channel mux with manual select or auto-scan.
// Define MUX_SCAN_BLANK_EN to blank outputs for one cycle on each channel change.
module mux_scan_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 50000
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(PRESCALE - 1);

  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_prev;
  logic [SEL_W-1:0]    sel_nxt;
  logic [SEL_W-1:0]    scan_nxt;
  logic [SEL_W-1:0]    cand;
  logic [CW-1:0]       pre_cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [WIDTH-1:0]    ch_data;
  logic [WIDTH-1:0]    dout_q;
  logic [CHANNELS-1:0] oh_nxt;
  logic [CHANNELS-1:0] oh_q;
  logic                chg_q;
  logic                tick;
  logic                sel_ok;
  logic                sel_chg;
  logic                blank;
  logic                found;
  int                  idx;

  assign tick    = (pre_cnt == CNT_TOP);
  assign sel_ok  = (int'(bus.sel_in) < CHANNELS);
  assign sel_chg = (sel_q != sel_prev);

`ifdef MUX_SCAN_BLANK_EN
  assign blank = sel_chg;
`else
  assign blank = 1'b0;
`endif

  // First enabled channel after sel_q, cyclic; holds if none.
  always_comb begin
    scan_nxt = sel_q;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int i = 1; i < CHANNELS; i++) begin
      idx = int'(sel_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = SEL_W'(idx);
      if (!found && bus.chan_en[cand]) begin
        scan_nxt = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    oh_nxt  = '0;
    ch_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      oh_nxt[k] = bus.chan_en[k] && (sel_q == SEL_W'(k));
      if (sel_q == SEL_W'(k)) ch_data = bus.din[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    cnt_nxt = pre_cnt;
    sel_nxt = sel_q;
    if (!bus.mode) begin
      cnt_nxt = '0;
      if (sel_ok) sel_nxt = bus.sel_in;
    end else if (tick) begin
      cnt_nxt = '0;
      sel_nxt = scan_nxt;
    end else begin
      cnt_nxt = pre_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q    <= '0;
      sel_prev <= '0;
      pre_cnt  <= '0;
      dout_q   <= '0;
      oh_q     <= '0;
      chg_q    <= 1'b0;
    end else begin
      sel_q    <= sel_nxt;
      sel_prev <= sel_q;
      pre_cnt  <= cnt_nxt;
      dout_q   <= (blank || !(|oh_nxt)) ? '0 : ch_data;
      oh_q     <= blank ? '0 : oh_nxt;
      chg_q    <= sel_chg;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel_out    = sel_q;
  assign bus.onehot_out = oh_q;
  assign bus.chg_out    = chg_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: randomized and directed checks of mux_scan_n
// against a behavioural model of selection, scan and output rules.
module tb_mux_scan_n;

  localparam int W = 4;
  localparam int C = 4;
  localparam int S = 2;
  localparam int P = 3;
`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mux_scan_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus ();
  mux_scan_if #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) bus3 ();

  mux_scan_n #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .PRESCALE(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  mux_scan_n #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .PRESCALE(1)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  int         m_sel = 0;
  int         m_cnt = 0;
  int         m_prev = 0;
  logic [3:0] m_dout = '0;
  logic [3:0] m_oh = '0;
  logic       m_chg = 1'b0;

  function automatic int next_en(int s, logic [C-1:0] en);
    for (int i = 1; i < C; i++)
      if (en[(s + i) % C]) return (s + i) % C;
    return s;
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_dout, 2'(m_sel), m_oh, m_chg};
  endfunction

  function automatic logic [10:0] act_vec();
    return {bus.dout, bus.sel_out, bus.onehot_out, bus.chg_out};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [3:0] chv;
    bit         show;
    if (!rst_n) begin
      m_sel = 0; m_cnt = 0; m_prev = 0;
      m_dout = '0; m_oh = '0; m_chg = 1'b0;
    end else begin
      chv    = 4'(bus.din >> (m_sel * W));
      show   = bus.chan_en[m_sel] && !(BLANK && m_sel != m_prev);
      m_dout = show ? chv : 4'h0;
      m_oh   = show ? 4'(1 << m_sel) : 4'h0;
      m_chg  = (m_sel != m_prev);
      m_prev = m_sel;
      if (!bus.mode) begin
        m_cnt = 0;
        if (int'(bus.sel_in) < C) m_sel = int'(bus.sel_in);
      end else if (m_cnt == P - 1) begin
        m_cnt = 0;
        m_sel = next_en(m_sel, bus.chan_en);
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.din = 16'hABCD; bus.mode = 1'b1;
    bus.sel_in = 2'd3; bus.chan_en = 4'hF;
    tick(); tick();
    checks++;
    if (act_vec() !== 11'h0)
      $display("FAIL reset_outputs got=%h want=%h", act_vec(), 11'h0);
    else passed++;
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL reset_model got=%h want=%h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_manual();
    rst_n = 1'b1;
    bus.mode = 1'b0; bus.chan_en = 4'hF;
    bus.din = 16'h4321; bus.sel_in = 2'd0;
    tick(); tick();
    bus.sel_in = 2'd2;
    tick();
    checks++;
    if (bus.sel_out !== 2'd2)
      $display("FAIL manual_sel got=%0d want=2", bus.sel_out);
    else passed++;
    tick();
    checks++;
    if ({bus.dout, bus.onehot_out, bus.chg_out} !==
        {BLANK ? 4'h0 : 4'h3, BLANK ? 4'b0000 : 4'b0100, 1'b1})
      $display("FAIL manual_out got=%h/%b/%b", bus.dout,
               bus.onehot_out, bus.chg_out);
    else passed++;
    tick();
    checks++;
    if ({bus.dout, bus.onehot_out, bus.chg_out} !== {4'h3, 4'b0100, 1'b0})
      $display("FAIL manual_settle got=%h/%b/%b", bus.dout,
               bus.onehot_out, bus.chg_out);
    else passed++;
  endtask

  task automatic test_auto();
    int steps = 0;
    bus.mode = 1'b0; bus.sel_in = 2'd0; bus.chan_en = 4'hF;
    tick(); tick();
    bus.mode = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.chg_out === 1'b1) steps++;
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL auto_cycle%0d got=%h want=%h", i, act_vec(), exp_vec());
      else passed++;
      if (i % 3 == 0) begin
        checks++;
        if (int'(bus.sel_out) !== (i / 3) % 4)
          $display("FAIL auto_step got=%0d want=%0d", bus.sel_out, (i / 3) % 4);
        else passed++;
      end
    end
    checks++;
    if (steps !== 4)
      $display("FAIL auto_chg_count got=%0d want=4", steps);
    else passed++;
  endtask

  task automatic test_skip_wrap();
    logic [1:0] held;
    bus.mode = 1'b0; bus.sel_in = 2'd0; bus.chan_en = 4'b1001;
    tick(); tick();
    bus.mode = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL skip_cycle%0d got=%h want=%h", i, act_vec(), exp_vec());
      else passed++;
      if (i % 3 == 0) begin
        checks++;
        if (bus.sel_out !== (((i / 3) % 2 == 1) ? 2'd3 : 2'd0))
          $display("FAIL skip_seq got=%0d at step %0d", bus.sel_out, i / 3);
        else passed++;
      end
    end
    held = bus.sel_out;
    bus.chan_en = 4'h0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({bus.dout, bus.onehot_out, bus.sel_out} !== {4'h0, 4'h0, held})
      $display("FAIL all_disabled got=%h/%b/%0d want=0/0/%0d", bus.dout,
               bus.onehot_out, bus.sel_out, held);
    else passed++;
  endtask

  task automatic test_range_switch();
    bus.mode = 1'b0; bus.sel_in = 2'd1; bus.chan_en = 4'hF;
    tick(); tick();
    bus.mode = 1'b1;
    tick();
    bus.mode = 1'b0;
    tick();
    bus.mode = 1'b1;
    tick(); tick();
    checks++;
    if (bus.sel_out !== 2'd1)
      $display("FAIL switch_early got=%0d want=1", bus.sel_out);
    else passed++;
    tick();
    checks++;
    if (bus.sel_out !== 2'd2)
      $display("FAIL switch_advance got=%0d want=2", bus.sel_out);
    else passed++;
    bus.mode = 1'b0; bus.sel_in = 2'd0;
    tick();
    checks++;
    if (bus.sel_out !== 2'd0)
      $display("FAIL switch_load got=%0d want=0", bus.sel_out);
    else passed++;
    bus3.sel_in = 2'd1;
    tick(); tick();
    checks++;
    if (bus3.sel_out !== 2'd1)
      $display("FAIL range_load got=%0d want=1", bus3.sel_out);
    else passed++;
    bus3.sel_in = 2'd3;
    tick(); tick();
    checks++;
    if (bus3.sel_out !== 2'd1)
      $display("FAIL range_hold got=%0d want=1", bus3.sel_out);
    else passed++;
    bus3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int'(bus3.sel_out) !== (2 + i) % 3)
        $display("FAIL prescale1 got=%0d want=%0d", bus3.sel_out, (2 + i) % 3);
      else passed++;
    end
  endtask

  task automatic test_blank();
    int n = 0;
    bus.mode = 1'b0; bus.sel_in = 2'd1;
    bus.chan_en = 4'hF; bus.din = 16'h4321;
    tick(); tick();
    bus.mode = 1'b1;
    while (bus.sel_out !== 2'd2 && n < 5) begin
      tick();
      n++;
    end
    checks++;
    if (bus.sel_out !== 2'd2)
      $display("FAIL blank_timeout got=%0d want=2", bus.sel_out);
    else passed++;
    tick();
    checks++;
    if ({bus.dout, bus.onehot_out, bus.chg_out} !==
        {BLANK ? 4'h0 : 4'h3, BLANK ? 4'b0000 : 4'b0100, 1'b1})
      $display("FAIL blank_cycle got=%h/%b/%b", bus.dout,
               bus.onehot_out, bus.chg_out);
    else passed++;
    tick();
    checks++;
    if ({bus.dout, bus.onehot_out, bus.chg_out} !== {4'h3, 4'b0100, 1'b0})
      $display("FAIL blank_after got=%h/%b/%b", bus.dout,
               bus.onehot_out, bus.chg_out);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 9) == 0) bus.chan_en = 4'($urandom);
      bus.sel_in = 2'($urandom);
      bus.din = 16'($urandom);
      tick();
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL random_cycle%0d got=%h want=%h", i, act_vec(), exp_vec());
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus3.din = 12'h321; bus3.mode = 1'b0;
    bus3.sel_in = 2'd0; bus3.chan_en = 3'b111;
    test_reset();
    test_manual();
    test_auto();
    test_skip_wrap();
    test_range_switch();
    test_blank();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
